mm_stream_tx: RTL and testbench
===============================

MM_STREAM_TX -- requirements
Module: mm_stream_tx

Interface
REQ-001 clk  input  1  rising-edge clock.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 start  input  1  one-cycle pulse; begins one transaction when in IDLE; ignored otherwise.
REQ-004 dim1, dim2  input  4 each  {rows-1[3:2], cols-1[1:0]} of mat1/mat2; sampled on start.
REQ-005 wr_en, wr_sel, wr_addr[3:0], wr_data[7:0]  input  element load port; wr_sel 0=mat1, 1=mat2; addr = row*4+col; accepted only in IDLE/DONE.
REQ-006 in_data  output  8  element to multiplier.
REQ-007 col_end, row_end  output  1 each  last column of a row / last row of a matrix.
REQ-008 busy, valid, is_legal, change_row  input  1 each  multiplier status; is_legal high with valid means the matrices are NOT multiplicable.
REQ-009 out_data  input  20  signed result element.
REQ-010 res_addr  input  4  result buffer read address, row*4+col.
REQ-011 res_data  output  20  combinational read of result buffer.
REQ-012 res_count  output  5  results captured in current transaction.
REQ-013 done  output  1  one-cycle pulse at transaction end.
REQ-014 err  output  4  sticky: [0] illegal reported, [1] legality mismatch, [2] change_row mismatch, [3] timeout.

Function
REQ-015 FSM states IDLE, SEND1, SEND2, WAIT_RES, FINISH; IDLE->SEND1 on start.
REQ-016 SEND1/SEND2: drive elements row-major, one per cycle while busy==0; busy==1 holds in_data/flags unchanged.
REQ-017 col_end high when col index == cols-1; row_end high when row index == rows-1; both high on final element.
REQ-018 SEND1 final element accepted -> SEND2 next cycle, no gap; SEND2 final element accepted -> WAIT_RES.
REQ-019 Outside SEND states, in_data, col_end, row_end SHALL be 0.
REQ-020 Expected legality: legal = (cols1 == rows2), computed on start.
REQ-021 WAIT_RES, valid with is_legal=1: set err[0]; set err[1] if legal; -> FINISH.
REQ-022 WAIT_RES, valid with is_legal=0: store out_data at (r,c), increment res_count; set err[1] if !legal; set err[2] if change_row != (c == cols2-1).
REQ-023 Capture index c wraps to 0 and r increments on last column; -> FINISH after rows1*cols2 results.
REQ-024 8-bit watchdog in WAIT_RES cleared on each valid; at 255 idle cycles set err[3] and -> FINISH.
REQ-025 FINISH: assert done one cycle, -> IDLE; err, res_count, buffer hold until next start.
REQ-026 start clears err, res_count, capture indices; buffer contents are not cleared.
REQ-027 valid outside WAIT_RES is ignored; wr_en outside IDLE/FINISH is ignored.

Reset
REQ-028 rst: state IDLE; in_data, col_end, row_end, done, err, res_count, indices, watchdog = 0.
REQ-029 rst mid-transaction aborts immediately; no done pulse; matrix stores and result buffer are not reset.

Structure
REQ-030 Shared package holds state encoding, MAX_DIM=4, DATA_W=8, RES_W=20, WDOG_MAX=255.
REQ-031 One sub-module mm_mat_store (16x8 register file, one write port, one combinational read port), instantiated twice; result buffer is inline 16x20.

Verification
REQ-032 mat1=[1 2;3 4], mat2=I2, busy low in SEND, MM returns 1,2,3,4 with change_row on 2nd and 4th -> res_data 1,2,3,4, res_count=4, err=0, done once.
REQ-033 dim1=1x3, dim2=2x2, MM returns one valid with is_legal=1 -> err=4'b0001, res_count=0, done.
REQ-034 4x4 all 255 both -> 32 streamed elements, col_end every 4th, row_end on elements 13-16 and 29-32; returned 260100 x16 stored, err=0.
REQ-035 busy raised 3 cycles mid-SEND1 -> in_data, col_end, row_end frozen 3 cycles; no element lost or duplicated.
REQ-036 WAIT_RES with no valid for 255 cycles -> err[3]=1, done pulse; change_row omitted on a row end -> err[2]=1.
REQ-037 rst asserted during SEND2 -> next cycle IDLE, outputs 0, no done; subsequent start completes normally.

Source files
------------

// File: rtl/mm_stream_tx_pkg.sv
// Shared types and constants for the matrix-multiplier stream transmitter.
package mm_stream_tx_pkg;
    localparam int MAX_DIM = 4;
    localparam int DATA_W  = 8;
    localparam int RES_W   = 20;
    localparam int ADDR_W  = 4;
    localparam logic [7:0] WDOG_MAX = 8'd255;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEND1    = 3'd1,
        SEND2    = 3'd2,
        WAIT_RES = 3'd3,
        FINISH   = 3'd4
    } state_t;

    function automatic logic [ADDR_W-1:0] elem_addr(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction
endpackage

// File: rtl/mm_mat_store.sv
// 16x8 element store: one synchronous write port, one combinational read port.
module mm_mat_store
    import mm_stream_tx_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);
    logic [DATA_W-1:0] mem_q [MAX_DIM*MAX_DIM];

    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_addr_i];
endmodule

// File: rtl/mm_stream_tx.sv
// Streams two matrices row-major to a multiplier (one element/cycle, stalled by busy)
// and captures its results into a 16x20 buffer, flagging protocol errors and timeouts.
module mm_stream_tx
    import mm_stream_tx_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       dim1,
    input  logic [3:0]       dim2,
    input  logic             wr_en,
    input  logic             wr_sel,
    input  logic [3:0]       wr_addr,
    input  logic [7:0]       wr_data,
    output logic [7:0]       in_data,
    output logic             col_end,
    output logic             row_end,
    input  logic             busy,
    input  logic             valid,
    input  logic             is_legal,
    input  logic             change_row,
    input  logic [RES_W-1:0] out_data,
    input  logic [3:0]       res_addr,
    output logic [RES_W-1:0] res_data,
    output logic [4:0]       res_count,
    output logic             done,
    output logic [3:0]       err
);
    state_t      state_q, state_d;
    logic [3:0]  dim1_q, dim1_d, dim2_q, dim2_d;
    logic        legal_q, legal_d;
    logic [1:0]  row_q, row_d, col_q, col_d;
    logic [1:0]  cap_r_q, cap_r_d, cap_c_q, cap_c_d;
    logic [4:0]  res_count_q, res_count_d;
    logic [3:0]  err_q, err_d;
    logic [7:0]  wdog_q, wdog_d;
    logic        buf_we;
    logic        in_send, load_ok;
    logic [1:0]  last_row, last_col;
    logic [7:0]  m1_rdata, m2_rdata;
    logic [RES_W-1:0] res_buf_q [MAX_DIM*MAX_DIM];

    assign load_ok = (state_q == IDLE) || (state_q == FINISH);
    assign in_send = (state_q == SEND1) || (state_q == SEND2);

    mm_mat_store u_mat1 (
        .clk       (clk),
        .wr_en_i   (wr_en && load_ok && !wr_sel),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_addr_i (elem_addr(row_q, col_q)),
        .rd_data_o (m1_rdata)
    );

    mm_mat_store u_mat2 (
        .clk       (clk),
        .wr_en_i   (wr_en && load_ok && wr_sel),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_addr_i (elem_addr(row_q, col_q)),
        .rd_data_o (m2_rdata)
    );

    // Bounds of whichever matrix is currently being streamed.
    assign last_row = (state_q == SEND2) ? dim2_q[3:2] : dim1_q[3:2];
    assign last_col = (state_q == SEND2) ? dim2_q[1:0] : dim1_q[1:0];

    always_comb begin
        state_d     = state_q;
        dim1_d      = dim1_q;
        dim2_d      = dim2_q;
        legal_d     = legal_q;
        row_d       = row_q;
        col_d       = col_q;
        cap_r_d     = cap_r_q;
        cap_c_d     = cap_c_q;
        res_count_d = res_count_q;
        err_d       = err_q;
        wdog_d      = wdog_q;
        buf_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = SEND1;
                    dim1_d      = dim1;
                    dim2_d      = dim2;
                    legal_d     = (dim1[1:0] == dim2[3:2]);
                    row_d       = 2'd0;
                    col_d       = 2'd0;
                    cap_r_d     = 2'd0;
                    cap_c_d     = 2'd0;
                    res_count_d = 5'd0;
                    err_d       = 4'd0;
                    wdog_d      = 8'd0;
                end
            end
            SEND1, SEND2: begin
                if (!busy) begin
                    if (col_q == last_col) begin
                        col_d = 2'd0;
                        if (row_q == last_row) begin
                            row_d   = 2'd0;
                            wdog_d  = 8'd0;
                            state_d = (state_q == SEND1) ? SEND2 : WAIT_RES;
                        end else begin
                            row_d = row_q + 2'd1;
                        end
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
            end
            WAIT_RES: begin
                if (valid) begin
                    wdog_d = 8'd0;
                    if (is_legal) begin
                        err_d[0] = 1'b1;
                        if (legal_q) err_d[1] = 1'b1;
                        state_d = FINISH;
                    end else begin
                        buf_we      = 1'b1;
                        res_count_d = res_count_q + 5'd1;
                        if (!legal_q) err_d[1] = 1'b1;
                        if (change_row != (cap_c_q == dim2_q[1:0])) err_d[2] = 1'b1;
                        if (cap_c_q == dim2_q[1:0]) begin
                            cap_c_d = 2'd0;
                            if (cap_r_q == dim1_q[3:2]) state_d = FINISH;
                            else cap_r_d = cap_r_q + 2'd1;
                        end else begin
                            cap_c_d = cap_c_q + 2'd1;
                        end
                    end
                end else if (wdog_q == WDOG_MAX - 8'd1) begin
                    err_d[3] = 1'b1;
                    state_d  = FINISH;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            dim1_q      <= 4'd0;
            dim2_q      <= 4'd0;
            legal_q     <= 1'b0;
            row_q       <= 2'd0;
            col_q       <= 2'd0;
            cap_r_q     <= 2'd0;
            cap_c_q     <= 2'd0;
            res_count_q <= 5'd0;
            err_q       <= 4'd0;
            wdog_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            dim1_q      <= dim1_d;
            dim2_q      <= dim2_d;
            legal_q     <= legal_d;
            row_q       <= row_d;
            col_q       <= col_d;
            cap_r_q     <= cap_r_d;
            cap_c_q     <= cap_c_d;
            res_count_q <= res_count_d;
            err_q       <= err_d;
            wdog_q      <= wdog_d;
        end
    end

    // Result buffer keeps its contents across reset and start.
    always_ff @(posedge clk) begin
        if (buf_we && !rst) res_buf_q[elem_addr(cap_r_q, cap_c_q)] <= out_data;
    end

    assign in_data   = (state_q == SEND1) ? m1_rdata : (state_q == SEND2) ? m2_rdata : 8'd0;
    assign col_end   = in_send && (col_q == last_col);
    assign row_end   = in_send && (row_q == last_row);
    assign res_data  = res_buf_q[res_addr];
    assign res_count = res_count_q;
    assign done      = (state_q == FINISH);
    assign err       = err_q;
endmodule

// File: tb/tb_mm_stream_tx.sv
// Directed self-checking bench for mm_stream_tx.
module tb_mm_stream_tx;
    logic        clk = 1'b0;
    logic        rst, start, wr_en, wr_sel, busy, valid, is_legal, change_row;
    logic [3:0]  dim1, dim2, wr_addr, res_addr;
    logic [7:0]  wr_data, in_data;
    logic        col_end, row_end, done;
    logic [19:0] out_data, res_data;
    logic [4:0]  res_count;
    logic [3:0]  err;
    logic [7:0]  m1 [16];
    logic [7:0]  m2 [16];
    int checks = 0;
    int errors = 0;

    mm_stream_tx dut (
        .clk(clk), .rst(rst), .start(start), .dim1(dim1), .dim2(dim2),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .in_data(in_data), .col_end(col_end), .row_end(row_end),
        .busy(busy), .valid(valid), .is_legal(is_legal), .change_row(change_row),
        .out_data(out_data), .res_addr(res_addr), .res_data(res_data),
        .res_count(res_count), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic sel, input logic [3:0] addr, input logic [7:0] data);
        wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
        step();
        wr_en = 1'b0;
        if (sel) m2[addr] = data;
        else     m1[addr] = data;
    endtask

    task automatic kick(input logic [3:0] d1, input logic [3:0] d2);
        dim1 = d1; dim2 = d2; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic result(input logic [19:0] v, input logic cr, input logic il);
        valid = 1'b1; out_data = v; change_row = cr; is_legal = il;
        step();
        valid = 1'b0; change_row = 1'b0; is_legal = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        checks++; if (in_data !== 8'd0) begin errors++; $display("FAIL reset_in_data: got %h want 00", in_data); end
        checks++; if ({col_end, row_end} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {col_end, row_end}); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (err !== 4'd0) begin errors++; $display("FAIL reset_err: got %b want 0000", err); end
        checks++; if (res_count !== 5'd0) begin errors++; $display("FAIL reset_res_count: got %0d want 0", res_count); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [7:0] e;
        int dcnt;
        load(1'b0, 4'd0, 8'd1); load(1'b0, 4'd1, 8'd2); load(1'b0, 4'd4, 8'd3); load(1'b0, 4'd5, 8'd4);
        load(1'b1, 4'd0, 8'd1); load(1'b1, 4'd1, 8'd0); load(1'b1, 4'd4, 8'd0); load(1'b1, 4'd5, 8'd1);
        kick(4'b0101, 4'b0101);
        for (int p = 0; p < 2; p++)
            for (int r = 0; r < 2; r++)
                for (int c = 0; c < 2; c++) begin
                    e = (p == 0) ? m1[r*4+c] : m2[r*4+c];
                    checks++;
                    if ({in_data, col_end, row_end} !== {e, c == 1, r == 1}) begin
                        errors++;
                        $display("FAIL basic_stream p%0d r%0d c%0d: got %h/%b/%b want %h/%b/%b",
                                 p, r, c, in_data, col_end, row_end, e, c == 1, r == 1);
                    end
                    step();
                end
        checks++; if (in_data !== 8'd0) begin errors++; $display("FAIL basic_idle_data: got %h want 00", in_data); end
        result(20'd1, 1'b0, 1'b0); result(20'd2, 1'b1, 1'b0);
        result(20'd3, 1'b0, 1'b0); result(20'd4, 1'b1, 1'b0);
        dcnt = 0;
        for (int i = 0; i < 6; i++) begin if (done === 1'b1) dcnt++; step(); end
        checks++; if (dcnt != 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", dcnt); end
        checks++; if (res_count !== 5'd4) begin errors++; $display("FAIL basic_res_count: got %0d want 4", res_count); end
        checks++; if (err !== 4'd0) begin errors++; $display("FAIL basic_err: got %b want 0000", err); end
        for (int k = 0; k < 4; k++) begin
            res_addr = 4'((k / 2) * 4 + (k % 2));
            #1;
            checks++;
            if (res_data !== 20'(k + 1)) begin
                errors++; $display("FAIL basic_res_data[%0d]: got %0d want %0d", res_addr, res_data, k + 1);
            end
        end
    endtask

    task automatic test_illegal();
        kick(4'b0010, 4'b0101);
        for (int i = 0; i < 7; i++) step();
        checks++; if ({in_data, col_end, row_end} !== 10'd0) begin errors++; $display("FAIL illegal_wait_outputs: got %h/%b/%b want 0", in_data, col_end, row_end); end
        result(20'd0, 1'b0, 1'b1);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL illegal_done: got %b want 1", done); end
        checks++; if (err !== 4'b0001) begin errors++; $display("FAIL illegal_err: got %b want 0001", err); end
        checks++; if (res_count !== 5'd0) begin errors++; $display("FAIL illegal_res_count: got %0d want 0", res_count); end
        step();
    endtask

    task automatic test_full_4x4();
        int ce_cnt, re_cnt, bad, dcnt;
        for (int a = 0; a < 16; a++) begin load(1'b0, 4'(a), 8'd255); load(1'b1, 4'(a), 8'd255); end
        kick(4'b1111, 4'b1111);
        ce_cnt = 0; re_cnt = 0; bad = 0;
        for (int i = 0; i < 32; i++) begin
            if (col_end === 1'b1) ce_cnt++;
            if (row_end === 1'b1) re_cnt++;
            if ({in_data, col_end, row_end} !== {8'd255, (i % 4) == 3, (i % 16) >= 12}) bad++;
            step();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL full_stream: %0d bad elements, want 0", bad); end
        checks++; if (ce_cnt != 8) begin errors++; $display("FAIL full_col_end_count: got %0d want 8", ce_cnt); end
        checks++; if (re_cnt != 8) begin errors++; $display("FAIL full_row_end_count: got %0d want 8", re_cnt); end
        for (int k = 0; k < 16; k++) result(20'd260100, (k % 4) == 3, 1'b0);
        dcnt = 0;
        for (int i = 0; i < 4; i++) begin if (done === 1'b1) dcnt++; step(); end
        checks++; if (dcnt != 1) begin errors++; $display("FAIL full_done_count: got %0d want 1", dcnt); end
        checks++; if (err !== 4'd0) begin errors++; $display("FAIL full_err: got %b want 0000", err); end
        checks++; if (res_count !== 5'd16) begin errors++; $display("FAIL full_res_count: got %0d want 16", res_count); end
        bad = 0;
        for (int a = 0; a < 16; a++) begin
            res_addr = 4'(a);
            #1;
            if (res_data !== 20'd260100) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL full_res_data: %0d entries differ from 260100", bad); end
    endtask

    task automatic test_busy_stall();
        logic [7:0] e;
        int p, r, c, dcnt;
        load(1'b0, 4'd0, 8'd10); load(1'b0, 4'd1, 8'd20); load(1'b0, 4'd4, 8'd30); load(1'b0, 4'd5, 8'd40);
        load(1'b1, 4'd0, 8'd5);  load(1'b1, 4'd1, 8'd6);  load(1'b1, 4'd4, 8'd7);  load(1'b1, 4'd5, 8'd8);
        kick(4'b0101, 4'b0101);
        checks++; if (in_data !== 8'd10) begin errors++; $display("FAIL busy_first: got %0d want 10", in_data); end
        step();
        busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({in_data, col_end, row_end} !== {8'd20, 1'b1, 1'b0}) begin
                errors++; $display("FAIL busy_hold[%0d]: got %0d/%b/%b want 20/1/0", i, in_data, col_end, row_end);
            end
            if (i == 0) begin wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd1; wr_data = 8'd99; end
            else wr_en = 1'b0;
            step();
        end
        busy = 1'b0; wr_en = 1'b0;
        for (int i = 1; i < 8; i++) begin
            p = i / 4; r = (i % 4) / 2; c = i % 2;
            e = (p == 0) ? m1[r*4+c] : m2[r*4+c];
            checks++;
            if ({in_data, col_end, row_end} !== {e, c == 1, r == 1}) begin
                errors++; $display("FAIL busy_stream[%0d]: got %0d/%b/%b want %0d/%b/%b",
                                   i, in_data, col_end, row_end, e, c == 1, r == 1);
            end
            step();
        end
        result(20'd1, 1'b0, 1'b0); result(20'd2, 1'b1, 1'b0);
        result(20'd3, 1'b0, 1'b0); result(20'd4, 1'b0, 1'b0);
        dcnt = 0;
        for (int i = 0; i < 4; i++) begin if (done === 1'b1) dcnt++; step(); end
        checks++; if (dcnt != 1) begin errors++; $display("FAIL busy_done_count: got %0d want 1", dcnt); end
        checks++; if (err !== 4'b0100) begin errors++; $display("FAIL change_row_err: got %b want 0100", err); end
    endtask

    task automatic test_watchdog();
        int n;
        kick(4'b0000, 4'b0000);
        step(); step();
        n = 0;
        while (done !== 1'b1 && n < 400) begin step(); n++; end
        checks++; if (n != 255) begin errors++; $display("FAIL wdog_cycles: got %0d want 255", n); end
        checks++; if (err !== 4'b1000) begin errors++; $display("FAIL wdog_err: got %b want 1000", err); end
        step();
        checks++; if ({done, err} !== 5'b0_1000) begin errors++; $display("FAIL wdog_hold: got done=%b err=%b want 0/1000", done, err); end
    endtask

    task automatic test_reset_abort();
        int dcnt;
        kick(4'b0101, 4'b0101);
        for (int i = 0; i < 5; i++) step();
        checks++; if (in_data !== 8'd6) begin errors++; $display("FAIL abort_in_send2: got %0d want 6", in_data); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if ({in_data, col_end, row_end} !== 10'd0) begin errors++; $display("FAIL abort_outputs: got %h/%b/%b want 0", in_data, col_end, row_end); end
        checks++; if ({err, res_count} !== 9'd0) begin errors++; $display("FAIL abort_status: got err=%b cnt=%0d want 0", err, res_count); end
        valid = 1'b1; out_data = 20'd77;
        dcnt = 0;
        for (int i = 0; i < 5; i++) begin if (done === 1'b1) dcnt++; step(); end
        valid = 1'b0;
        checks++; if (dcnt != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", dcnt); end
        checks++; if (res_count !== 5'd0) begin errors++; $display("FAIL idle_valid_ignored: got %0d want 0", res_count); end
        kick(4'b0101, 4'b0101);
        for (int i = 0; i < 8; i++) step();
        result(20'd11, 1'b0, 1'b0); result(20'd22, 1'b1, 1'b0);
        result(20'd33, 1'b0, 1'b0); result(20'd44, 1'b1, 1'b0);
        dcnt = 0;
        for (int i = 0; i < 4; i++) begin if (done === 1'b1) dcnt++; step(); end
        checks++; if (dcnt != 1) begin errors++; $display("FAIL rerun_done_count: got %0d want 1", dcnt); end
        checks++; if ({err, res_count} !== {4'd0, 5'd4}) begin errors++; $display("FAIL rerun_status: got err=%b cnt=%0d want 0000/4", err, res_count); end
        res_addr = 4'd5;
        #1;
        checks++; if (res_data !== 20'd44) begin errors++; $display("FAIL rerun_res_data: got %0d want 44", res_data); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dim1 = 4'd0; dim2 = 4'd0;
        wr_en = 1'b0; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 8'd0;
        busy = 1'b0; valid = 1'b0; is_legal = 1'b0; change_row = 1'b0;
        out_data = 20'd0; res_addr = 4'd0;
        test_reset();
        test_basic();
        test_illegal();
        test_full_4x4();
        test_busy_stall();
        test_watchdog();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
